// File: rtl/dcache_req_arbiter.sv
// Two-to-one data-cache request arbiter (LSU + PTW); DCACHE_ARB_RR_EN enables round-robin tie-break.
// Latency: grant registered one cycle after request; requester ack is combinational with dcache_ack_i.
// Backpressure: grant held, dcache_* stable, until dcache_ack_i; flushed LSU accesses drain silently.
module dcache_req_arbiter #(
  parameter int PALEN  = 34,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [SEL_W-1:0]  lsu_sel_i,
  input  logic [PALEN-1:0]  lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic              lsu_flush_i,
  output logic              lsu_ack_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  input  logic              ptw_req_i,
  input  logic [PALEN-1:0]  ptw_addr_i,
  output logic              ptw_ack_o,
  output logic [DATA_W-1:0] ptw_rdata_o,
  output logic              dcache_req_o,
  output logic              dcache_we_o,
  output logic [SEL_W-1:0]  dcache_sel_o,
  output logic [PALEN-1:0]  dcache_addr_o,
  output logic [DATA_W-1:0] dcache_wdata_o,
  input  logic              dcache_ack_i,
  input  logic [DATA_W-1:0] dcache_rdata_i
);

  typedef enum logic [1:0] {IDLE, LSU_BUSY, PTW_BUSY, DRAIN} state_t;

  state_t state;
  logic   lsu_elig;
  logic   ptw_win;

  assign lsu_elig = lsu_req_i && !lsu_flush_i;

`ifdef DCACHE_ARB_RR_EN
  // Set when the most recent grant went to the PTW.
  logic last_ptw;
  assign ptw_win = ptw_req_i && (!lsu_elig || !last_ptw);
`else
  assign ptw_win = ptw_req_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      dcache_req_o   <= 1'b0;
      dcache_we_o    <= 1'b0;
      dcache_sel_o   <= '0;
      dcache_addr_o  <= '0;
      dcache_wdata_o <= '0;
`ifdef DCACHE_ARB_RR_EN
      last_ptw       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ptw_win) begin
            state          <= PTW_BUSY;
            dcache_req_o   <= 1'b1;
            dcache_we_o    <= 1'b0;
            dcache_sel_o   <= '1;
            dcache_addr_o  <= ptw_addr_i;
            dcache_wdata_o <= '0;
`ifdef DCACHE_ARB_RR_EN
            last_ptw       <= 1'b1;
`endif
          end else if (lsu_elig) begin
            state          <= LSU_BUSY;
            dcache_req_o   <= 1'b1;
            dcache_we_o    <= lsu_we_i;
            dcache_sel_o   <= lsu_sel_i;
            dcache_addr_o  <= lsu_addr_i;
            dcache_wdata_o <= lsu_wdata_i;
`ifdef DCACHE_ARB_RR_EN
            last_ptw       <= 1'b0;
`endif
          end
        end
        LSU_BUSY: begin
          if (dcache_ack_i) begin
            state        <= IDLE;
            dcache_req_o <= 1'b0;
          end else if (lsu_flush_i) begin
            // The cache access is already issued; let it finish without reporting it.
            state <= DRAIN;
          end
        end
        default: begin
          if (dcache_ack_i) begin
            state        <= IDLE;
            dcache_req_o <= 1'b0;
          end
        end
      endcase
    end
  end

  assign lsu_ack_o   = rst_n && (state == LSU_BUSY) && dcache_ack_i && !lsu_flush_i;
  assign ptw_ack_o   = rst_n && (state == PTW_BUSY) && dcache_ack_i;
  assign lsu_rdata_o = dcache_rdata_i;
  assign ptw_rdata_o = dcache_rdata_i;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios plus randomized traffic vs. a transaction model.
module tb_dcache_req_arbiter;
  localparam int PALEN  = 34;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              lsu_req_i, lsu_we_i, lsu_flush_i, lsu_ack_o;
  logic [SEL_W-1:0]  lsu_sel_i;
  logic [PALEN-1:0]  lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i, lsu_rdata_o;
  logic              ptw_req_i, ptw_ack_o;
  logic [PALEN-1:0]  ptw_addr_i;
  logic [DATA_W-1:0] ptw_rdata_o;
  logic              dcache_req_o, dcache_we_o, dcache_ack_i;
  logic [SEL_W-1:0]  dcache_sel_o;
  logic [PALEN-1:0]  dcache_addr_o;
  logic [DATA_W-1:0] dcache_wdata_o, dcache_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  dcache_req_arbiter #(.PALEN(PALEN), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_sel_i(lsu_sel_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_flush_i(lsu_flush_i),
    .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o),
    .ptw_req_i(ptw_req_i), .ptw_addr_i(ptw_addr_i), .ptw_ack_o(ptw_ack_o),
    .ptw_rdata_o(ptw_rdata_o),
    .dcache_req_o(dcache_req_o), .dcache_we_o(dcache_we_o), .dcache_sel_o(dcache_sel_o),
    .dcache_addr_o(dcache_addr_o), .dcache_wdata_o(dcache_wdata_o),
    .dcache_ack_i(dcache_ack_i), .dcache_rdata_i(dcache_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    lsu_req_i = 0; lsu_we_i = 0; lsu_sel_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    lsu_flush_i = 0; ptw_req_i = 0; ptw_addr_i = '0; dcache_ack_i = 0; dcache_rdata_i = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    nxt(); nxt();
    dcache_ack_i = 1;
    #1;
    n_cmp++; if (dcache_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", dcache_req_o); end
    n_cmp++; if ({dcache_we_o, dcache_sel_o, dcache_addr_o, dcache_wdata_o} !== '0) begin
      n_err++; $display("FAIL reset_fields: got we=%b sel=%h addr=%h wdata=%h want all 0",
                        dcache_we_o, dcache_sel_o, dcache_addr_o, dcache_wdata_o); end
    n_cmp++; if ({lsu_ack_o, ptw_ack_o} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b%b want 00", lsu_ack_o, ptw_ack_o); end
    nxt();
    rst_n = 1;
    nxt();
    #1;
    n_cmp++; if ({lsu_ack_o, ptw_ack_o} !== 2'b00) begin n_err++; $display("FAIL idle_stray_ack: got %b%b want 00", lsu_ack_o, ptw_ack_o); end
    n_cmp++; if (dcache_req_o !== 1'b0) begin n_err++; $display("FAIL idle_stray_req: got %b want 0", dcache_req_o); end
    dcache_ack_i = 0;
  endtask

  task automatic test_lsu_load;
    nxt();
    lsu_req_i = 1; lsu_we_i = 0; lsu_sel_i = 4'hF; lsu_addr_i = 34'h0_8000_1000;
    #1;
    n_cmp++; if (dcache_req_o !== 1'b0) begin n_err++; $display("FAIL load_req_early: got %b want 0", dcache_req_o); end
    nxt(); #1;
    n_cmp++; if (dcache_req_o !== 1'b1) begin n_err++; $display("FAIL load_grant: got %b want 1", dcache_req_o); end
    n_cmp++; if (dcache_addr_o !== 34'h0_8000_1000 || dcache_we_o !== 1'b0) begin
      n_err++; $display("FAIL load_fields: got addr=%h we=%b want 080001000/0", dcache_addr_o, dcache_we_o); end
    for (int i = 0; i < 2; i++) begin
      nxt(); #1;
      n_cmp++; if ({lsu_ack_o, ptw_ack_o} !== 2'b00) begin n_err++; $display("FAIL load_wait_ack: got %b%b want 00", lsu_ack_o, ptw_ack_o); end
    end
    nxt();
    dcache_ack_i = 1; dcache_rdata_i = 32'hDEADBEEF;
    #1;
    n_cmp++; if (lsu_ack_o !== 1'b1 || ptw_ack_o !== 1'b0) begin n_err++; $display("FAIL load_ack: got lsu=%b ptw=%b want 1/0", lsu_ack_o, ptw_ack_o); end
    n_cmp++; if (lsu_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_rdata: got %h want deadbeef", lsu_rdata_o); end
    nxt();
    dcache_ack_i = 0; lsu_req_i = 0;
    #1;
    n_cmp++; if (dcache_req_o !== 1'b0) begin n_err++; $display("FAIL load_release: got %b want 0", dcache_req_o); end
  endtask

  task automatic test_simultaneous;
    bit first_lsu;
`ifdef DCACHE_ARB_RR_EN
    first_lsu = 1;
`else
    first_lsu = 0;
`endif
    nxt();
    ptw_req_i = 1; ptw_addr_i = 34'h2_0000_0040;
    lsu_req_i = 1; lsu_we_i = 1; lsu_sel_i = 4'h3; lsu_addr_i = 34'h0_0000_0100; lsu_wdata_i = 32'h1111_2222;
    nxt(); #1;
    n_cmp++; if (dcache_req_o !== 1'b1 || dcache_addr_o !== 34'h2_0000_0040) begin
      n_err++; $display("FAIL tie_ptw_addr: got req=%b addr=%h want 1/200000040", dcache_req_o, dcache_addr_o); end
    n_cmp++; if (dcache_we_o !== 1'b0 || dcache_sel_o !== 4'hF || dcache_wdata_o !== '0) begin
      n_err++; $display("FAIL tie_ptw_fields: got we=%b sel=%h wdata=%h want 0/f/0", dcache_we_o, dcache_sel_o, dcache_wdata_o); end
    dcache_ack_i = 1; dcache_rdata_i = 32'h1234_5678;
    #1;
    n_cmp++; if (ptw_ack_o !== 1'b1 || lsu_ack_o !== 1'b0 || ptw_rdata_o !== 32'h1234_5678) begin
      n_err++; $display("FAIL tie_ptw_ack: got ptw=%b lsu=%b rdata=%h want 1/0/12345678", ptw_ack_o, lsu_ack_o, ptw_rdata_o); end
    nxt();
    dcache_ack_i = 0; ptw_addr_i = 34'h2_0000_0080;
    #1;
    n_cmp++; if (dcache_req_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b want 0", dcache_req_o); end
    nxt(); #1;
    n_cmp++; if (dcache_req_o !== 1'b1 || dcache_addr_o !== (first_lsu ? 34'h0_0000_0100 : 34'h2_0000_0080)) begin
      n_err++; $display("FAIL tie2_winner: got req=%b addr=%h want lsu_first=%b", dcache_req_o, dcache_addr_o, first_lsu); end
    dcache_ack_i = 1; dcache_rdata_i = 32'hCAFE_0001;
    #1;
    n_cmp++; if (lsu_ack_o !== first_lsu || ptw_ack_o !== !first_lsu) begin
      n_err++; $display("FAIL tie2_ack: got lsu=%b ptw=%b want %b/%b", lsu_ack_o, ptw_ack_o, first_lsu, !first_lsu); end
    nxt();
    dcache_ack_i = 0;
    if (first_lsu) lsu_req_i = 0; else ptw_req_i = 0;
    nxt(); #1;
    n_cmp++; if (dcache_req_o !== 1'b1 || dcache_addr_o !== (first_lsu ? 34'h2_0000_0080 : 34'h0_0000_0100)) begin
      n_err++; $display("FAIL tie2_second: got req=%b addr=%h want lsu_first=%b", dcache_req_o, dcache_addr_o, first_lsu); end
    dcache_ack_i = 1;
    #1;
    n_cmp++; if (lsu_ack_o !== !first_lsu || ptw_ack_o !== first_lsu) begin
      n_err++; $display("FAIL tie2_second_ack: got lsu=%b ptw=%b", lsu_ack_o, ptw_ack_o); end
    nxt();
    clear_inputs();
  endtask

  task automatic test_store;
    nxt();
    lsu_req_i = 1; lsu_we_i = 1; lsu_sel_i = 4'b0011; lsu_addr_i = 34'h1_2345_6788; lsu_wdata_i = 32'h0000_A5A5;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      n_cmp++; if (dcache_req_o !== 1'b1 || dcache_we_o !== 1'b1 || dcache_sel_o !== 4'b0011 ||
                   dcache_wdata_o !== 32'h0000_A5A5 || dcache_addr_o !== 34'h1_2345_6788) begin
        n_err++; $display("FAIL store_hold[%0d]: got req=%b we=%b sel=%h wdata=%h addr=%h want 1/1/3/0000a5a5/123456788",
                          i, dcache_req_o, dcache_we_o, dcache_sel_o, dcache_wdata_o, dcache_addr_o); end
    end
    dcache_ack_i = 1;
    #1;
    n_cmp++; if (lsu_ack_o !== 1'b1) begin n_err++; $display("FAIL store_ack: got %b want 1", lsu_ack_o); end
    nxt();
    clear_inputs();
  endtask

  task automatic test_flush_mid;
    nxt();
    lsu_req_i = 1; lsu_addr_i = 34'h0_0000_2000;
    nxt();
    lsu_flush_i = 1; lsu_req_i = 0; ptw_req_i = 1; ptw_addr_i = 34'h3_0000_0010;
    nxt();
    lsu_flush_i = 0;
    #1;
    n_cmp++; if (dcache_req_o !== 1'b1 || dcache_addr_o !== 34'h0_0000_2000) begin
      n_err++; $display("FAIL drain_hold: got req=%b addr=%h want 1/000002000", dcache_req_o, dcache_addr_o); end
    nxt();
    dcache_ack_i = 1;
    #1;
    n_cmp++; if ({lsu_ack_o, ptw_ack_o} !== 2'b00) begin n_err++; $display("FAIL drain_ack: got %b%b want 00", lsu_ack_o, ptw_ack_o); end
    nxt();
    dcache_ack_i = 0;
    #1;
    n_cmp++; if (dcache_req_o !== 1'b0) begin n_err++; $display("FAIL drain_idle: got %b want 0", dcache_req_o); end
    nxt(); #1;
    n_cmp++; if (dcache_req_o !== 1'b1 || dcache_addr_o !== 34'h3_0000_0010 || dcache_we_o !== 1'b0) begin
      n_err++; $display("FAIL drain_ptw_after: got req=%b addr=%h we=%b want 1/300000010/0", dcache_req_o, dcache_addr_o, dcache_we_o); end
    dcache_ack_i = 1;
    #1;
    n_cmp++; if (ptw_ack_o !== 1'b1) begin n_err++; $display("FAIL drain_ptw_ack: got %b want 1", ptw_ack_o); end
    nxt();
    clear_inputs();
  endtask

  task automatic test_flush_idle;
    nxt();
    lsu_req_i = 1; lsu_flush_i = 1; lsu_addr_i = 34'h0_0000_3000;
    nxt();
    lsu_req_i = 0; lsu_flush_i = 0;
    #1;
    n_cmp++; if (dcache_req_o !== 1'b0) begin n_err++; $display("FAIL flush_idle: got %b want 0", dcache_req_o); end
  endtask

  task automatic test_reset_mid;
    nxt();
    ptw_req_i = 1; ptw_addr_i = 34'h0_0000_4000;
    nxt();
    rst_n = 0;
    nxt(); #1;
    n_cmp++; if (dcache_req_o !== 1'b0 || dcache_addr_o !== '0) begin
      n_err++; $display("FAIL rst_mid: got req=%b addr=%h want 0/0", dcache_req_o, dcache_addr_o); end
    rst_n = 1; ptw_req_i = 0; dcache_ack_i = 1;
    #1;
    n_cmp++; if (ptw_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_stray_ack: got %b want 0", ptw_ack_o); end
    nxt();
    clear_inputs();
  endtask

  // Transaction-level model: one outstanding grant, owner, and whether a flush has killed it.
  task automatic test_random;
    bit m_busy, m_own_ptw, m_killed, m_last_ptw;
    logic m_we;
    logic [SEL_W-1:0]  m_sel;
    logic [PALEN-1:0]  m_addr;
    logic [DATA_W-1:0] m_wdata;
    bit e_lack, e_pack, prev_lack, prev_pack, prev_flush, lsu_e, ptw_e, pick_ptw;
    clear_inputs();
    rst_n = 0;
    nxt(); nxt();
    rst_n = 1;
    m_busy = 0; m_own_ptw = 0; m_killed = 0; m_last_ptw = 0;
    m_we = 0; m_sel = '0; m_addr = '0; m_wdata = '0;
    prev_lack = 0; prev_pack = 0; prev_flush = 0;
    for (int c = 0; c < 1500; c++) begin
      nxt();
      if (prev_lack || prev_flush) lsu_req_i = 0;
      if (prev_pack) ptw_req_i = 0;
      if (!lsu_req_i && $urandom_range(2) == 0) begin
        lsu_req_i = 1; lsu_we_i = 1'($urandom); lsu_sel_i = SEL_W'($urandom);
        lsu_addr_i = {2'($urandom_range(3)), $urandom}; lsu_wdata_i = $urandom;
      end
      if (!ptw_req_i && $urandom_range(3) == 0) begin
        ptw_req_i = 1; ptw_addr_i = {2'($urandom_range(3)), $urandom};
      end
      lsu_flush_i = ($urandom_range(9) == 0);
      dcache_ack_i = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(11) == 0);
      dcache_rdata_i = $urandom;
      #1;
      e_lack = m_busy && !m_own_ptw && !m_killed && dcache_ack_i && !lsu_flush_i;
      e_pack = m_busy && m_own_ptw && dcache_ack_i;
      n_cmp++; if (dcache_req_o !== m_busy) begin n_err++; $display("FAIL rnd_req c=%0d: got %b want %b", c, dcache_req_o, m_busy); end
      if (m_busy) begin
        n_cmp++; if (dcache_we_o !== m_we || dcache_sel_o !== m_sel || dcache_addr_o !== m_addr || dcache_wdata_o !== m_wdata) begin
          n_err++; $display("FAIL rnd_fields c=%0d: got %b/%h/%h/%h want %b/%h/%h/%h", c, dcache_we_o, dcache_sel_o,
                            dcache_addr_o, dcache_wdata_o, m_we, m_sel, m_addr, m_wdata); end
      end
      n_cmp++; if (lsu_ack_o !== e_lack || ptw_ack_o !== e_pack) begin
        n_err++; $display("FAIL rnd_acks c=%0d: got lsu=%b ptw=%b want %b/%b", c, lsu_ack_o, ptw_ack_o, e_lack, e_pack); end
      if (e_lack) begin
        n_cmp++; if (lsu_rdata_o !== dcache_rdata_i) begin n_err++; $display("FAIL rnd_lsu_rdata c=%0d: got %h want %h", c, lsu_rdata_o, dcache_rdata_i); end
      end
      if (e_pack) begin
        n_cmp++; if (ptw_rdata_o !== dcache_rdata_i) begin n_err++; $display("FAIL rnd_ptw_rdata c=%0d: got %h want %h", c, ptw_rdata_o, dcache_rdata_i); end
      end
      prev_lack = e_lack; prev_pack = e_pack; prev_flush = lsu_flush_i;
      if (m_busy) begin
        if (dcache_ack_i) m_busy = 0;
        else if (!m_own_ptw && lsu_flush_i) m_killed = 1;
      end else begin
        lsu_e = lsu_req_i && !lsu_flush_i;
        ptw_e = ptw_req_i;
`ifdef DCACHE_ARB_RR_EN
        pick_ptw = ptw_e && (!lsu_e || !m_last_ptw);
`else
        pick_ptw = ptw_e;
`endif
        if (ptw_e || lsu_e) begin
          m_busy = 1; m_killed = 0; m_own_ptw = pick_ptw; m_last_ptw = pick_ptw;
          if (pick_ptw) begin
            m_we = 0; m_sel = '1; m_addr = ptw_addr_i; m_wdata = '0;
          end else begin
            m_we = lsu_we_i; m_sel = lsu_sel_i; m_addr = lsu_addr_i; m_wdata = lsu_wdata_i;
          end
        end
      end
    end
    nxt();
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_lsu_load();
    test_simultaneous();
    test_store();
    test_flush_mid();
    test_flush_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
